// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a fixed window of enabled
// cycles, snapshots the counts at window end and streams them out one channel per word.
module spike_rate_decoder #(
  parameter int NUM_CH = 4,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] spike_in,
  output logic [7:0]        rate_data,
  output logic [2:0]        rate_ch,
  output logic              rate_valid,
  input  logic              rate_ready,
  output logic              window_done,
  output logic              missed
);

  localparam int WC_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [WC_W-1:0]                wcnt_q, wcnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              sat_q, sat_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   snap_q, snap_d;
  logic [NUM_CH-1:0]              snap_sat_q, snap_sat_d;
  logic                           window_done_q, window_done_d;
  logic                           missed_q, missed_d;

  logic [NUM_CH-1:0][CNT_W-1:0]   fin_cnt;
  logic [NUM_CH-1:0]              fin_sat;
  logic                           win_end;
  logic                           handshake;
  logic                           can_load;
  logic                           load;

  // Counts including this cycle's spikes; these are what a window-end snapshot captures.
  always_comb begin
    fin_cnt = cnt_q;
    fin_sat = sat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (spike_in[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          fin_sat[i] = 1'b1;
        end else begin
          fin_cnt[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign win_end = en && (wcnt_q == WIN_LAST);

  always_comb begin
    wcnt_d = wcnt_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (en) begin
      if (win_end) begin
        wcnt_d = '0;
        cnt_d  = '0;
        sat_d  = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
        cnt_d  = fin_cnt;
        sat_d  = fin_sat;
      end
    end
  end

  // Valid/ready: a word transfers on a rising edge where rate_valid and rate_ready
  // are both high; while rate_valid is high and rate_ready low, rate_ch/rate_data hold.
  assign handshake = (state_q == S_SEND) && rate_ready;
  assign can_load  = (state_q == S_IDLE) || (handshake && (idx_q == IDX_LAST));
  assign load      = win_end && can_load;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    snap_sat_d    = snap_sat_q;
    window_done_d = load;
    missed_d      = win_end && !can_load;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SEND: begin
        if (handshake) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A fresh snapshot restarts readout even if the last word leaves on this edge.
    if (load) begin
      state_d    = S_SEND;
      idx_d      = '0;
      snap_d     = fin_cnt;
      snap_sat_d = fin_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wcnt_q        <= '0;
      cnt_q         <= '0;
      sat_q         <= '0;
      snap_q        <= '0;
      snap_sat_q    <= '0;
      window_done_q <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      cnt_q         <= cnt_d;
      sat_q         <= sat_d;
      snap_q        <= snap_d;
      snap_sat_q    <= snap_sat_d;
      window_done_q <= window_done_d;
      missed_q      <= missed_d;
    end
  end

  always_comb begin
    rate_valid = (state_q == S_SEND);
    rate_data  = '0;
    rate_ch    = '0;
    if (state_q == S_SEND) begin
      rate_ch                = 3'(idx_q);
      rate_data[CNT_W-1:0]   = snap_q[idx_q];
      rate_data[7]           = snap_sat_q[idx_q];
    end
  end

  assign window_done = window_done_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a transaction-level rate model pushes
// expected words at each window end; words are popped as the DUT hands them over.
module tb_spike_rate_decoder;

  localparam int NUM_CH = 4;
  localparam int WINDOW = 16;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] spike_in;
  logic [7:0] rate_data;
  logic [2:0] rate_ch;
  logic       rate_valid;
  logic       rate_ready;
  logic       window_done;
  logic       missed;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];
  int          mwcnt;
  int          mcnt[NUM_CH];
  logic        msat[NUM_CH];

  spike_rate_decoder #(
    .NUM_CH(NUM_CH),
    .WINDOW(WINDOW),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .rate_data  (rate_data),
    .rate_ch    (rate_ch),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .window_done(window_done),
    .missed     (missed)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mwcnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      mcnt[i] = 0;
      msat[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, compare/pop at negedge, update model, check pulses after edge.
  task automatic cycle(input logic e, input logic [3:0] sp, input logic rdy);
    logic exp_wd;
    logic exp_ms;
    en         = e;
    spike_in   = sp;
    rate_ready = rdy;
    @(negedge clk);
    chk("rate_valid", rate_valid, exp_q.size() != 0);
    if (rate_valid === 1'b1 && exp_q.size() != 0) begin
      chk("word_ch_data", {rate_ch, rate_data}, exp_q[0]);
      if (rdy) void'(exp_q.pop_front());
    end
    exp_wd = 1'b0;
    exp_ms = 1'b0;
    if (e) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sp[i]) begin
          if (mcnt[i] == CMAX) msat[i] = 1'b1;
          else mcnt[i]++;
        end
      end
      if (mwcnt == WINDOW - 1) begin
        if (exp_q.size() == 0) begin
          for (int i = 0; i < NUM_CH; i++)
            exp_q.push_back({3'(i), msat[i], 3'b000, 4'(mcnt[i])});
          exp_wd = 1'b1;
        end else begin
          exp_ms = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          mcnt[i] = 0;
          msat[i] = 1'b0;
        end
        mwcnt = 0;
      end else begin
        mwcnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("window_done", window_done, exp_wd);
    chk("missed", missed, exp_ms);
    if (exp_wd) chk("first_word_latency", rate_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rate_valid", rate_valid, 1'b0);
    chk("rst_rate_data", rate_data, 8'h00);
    chk("rst_rate_ch", rate_ch, 3'd0);
    chk("rst_window_done", window_done, 1'b0);
    chk("rst_missed", missed, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [3:0] basic_sp(input int k);
    return {1'b0, (k == 5), (k % 2 == 0), 1'b1};
  endfunction

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    spike_in   = '0;
    rate_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("init_rate_valid", rate_valid, 1'b0);
    chk("init_rate_data", rate_data, 8'h00);
    chk("init_rate_ch", rate_ch, 3'd0);
    chk("init_window_done", window_done, 1'b0);
    chk("init_missed", missed, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic rates: ch0 every cycle (saturates), ch1 every 2nd, ch2 once, ch3 never
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, basic_sp(k), 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    // reset in the middle of readout, after ch1 is accepted
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, basic_sp(k), 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    do_reset();
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, {(k % 4 == 0), 2'b00, (k == 3)}, 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    // backpressure on ch1 for 5 cycles
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, basic_sp(k), 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    repeat (5) cycle(1'b0, 4'h0, 1'b0);
    repeat (5) cycle(1'b0, 4'h0, 1'b1);

    // dropped window: second window (all counts 3) ends while readout is stalled
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, basic_sp(k), 1'b1);
    for (int k = 0; k < WINDOW; k++)
      cycle(1'b1, (k == 0 || k == 5 || k == 10) ? 4'hF : 4'h0, 1'b0);
    repeat (4) cycle(1'b0, 4'h0, 1'b0);
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    // enable freeze for 10 cycles mid-window with toggling spikes
    for (int k = 0; k < WINDOW; k++) begin
      if (k == 8) repeat (10) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b1);
      cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
    end
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    // boundary spike on ch2 in the window-end cycle, then an empty window
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, (k == WINDOW - 1) ? 4'b0100 : 4'h0, 1'b1);
    for (int k = 0; k < WINDOW; k++) cycle(1'b1, 4'h0, 1'b1);
    repeat (6) cycle(1'b0, 4'h0, 1'b1);

    // random spikes and random backpressure across several windows
    repeat (4) begin
      for (int k = 0; k < WINDOW; k++)
        cycle(1'b1, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    repeat (12) cycle(1'b0, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive end of the neuron spike interface: takes the 4 spike lines produced by the LIF neuron array and counts spikes per channel over a fixed window of clock cycles.
- At each window end, snapshots the counts and streams them out one channel at a time on an 8-bit valid/ready bus, which the top level time-multiplexes onto uo_out.
- Closes the loop for rate-coded testing: spike trains in, per-channel firing rates out.

Parameters:
- NUM_CH, 4, number of spike channels (2..8)
- WINDOW, 16, window length in enabled clock cycles (>= NUM_CH+2)
- CNT_W, 4, per-channel counter width (<= 7)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  counting enable; low freezes the window counter and spike counters
- spike_in  input  NUM_CH  one spike flag per channel, sampled each enabled cycle
- rate_data  output  8  {sat, zeros, count[CNT_W-1:0]} for the channel on rate_ch
- rate_ch  output  3  channel index of rate_data
- rate_valid  output  1  rate_data/rate_ch valid
- rate_ready  input  1  consumer accepts the word when high with rate_valid
- window_done  output  1  one-cycle pulse: snapshot taken
- missed  output  1  one-cycle pulse: window ended while readout still busy, so the snapshot was dropped

Behaviour:
- Reset (async, any time): window counter, all spike counters, snapshot, sat flags = 0; FSM to IDLE; rate_valid = 0, rate_data = 0, rate_ch = 0, window_done = 0, missed = 0.
- Window counter wcnt counts 0..WINDOW-1 on cycles with en = 1, then wraps to 0. When en = 0, wcnt and the counters hold.
- Spike counting happens when en = 1 and spike_in[i] = 1: cnt[i] increments.
  - Saturation: if cnt[i] = 2^CNT_W-1, it holds and sat[i] is set. sat[i] is sticky until window end.
- Window end is the enabled cycle with wcnt = WINDOW-1. A spike in this cycle is included in the snapshot.
  - Clock edge at window end: cnt[i] and sat[i] are cleared to 0; the next window starts with empty counters, no cycles lost.
  - If the FSM is IDLE, or is in SEND with the last channel handshaking in that same cycle, snap[i] <= final count and sat; window_done = 1 next cycle.
  - Otherwise the snapshot is discarded, snap is unchanged, and missed = 1 next cycle.
- Readout FSM:
  - IDLE: rate_valid = 0. Moves to SEND with idx = 0 on the edge that loads a snapshot.
  - SEND: rate_valid = 1; rate_ch = idx; rate_data = {sat[idx], zero pad, snap[idx]}.
    - Outputs stay stable while rate_valid = 1 and rate_ready = 0.
    - On an edge with rate_valid & rate_ready: if idx < NUM_CH-1, idx + 1; else go to IDLE. If a snapshot loads on that same edge, go instead to SEND with idx = 0.
  - Latency: first word valid on the cycle after the window-end edge (same cycle window_done is high).
  - Minimum readout is NUM_CH cycles with rate_ready held high.
- rate_ready high while rate_valid = 0 has no effect.
- en going low does not stall readout; only counting freezes.
- rate_data width rule: sat at bit 7, count zero-extended in bits CNT_W-1..0, bits 6..CNT_W = 0.

Test Plan:
- Reset mid-readout: after ch1 is accepted, assert rst for 1 cycle -> rate_valid = 0 immediately (async), all outputs 0. Next window starts from wcnt = 0 with empty counts.
- Basic rates: en = 1, rate_ready = 1, 16-cycle window with spike_in[0] every cycle, [1] every 2nd, [2] once, [3] never.
  - Expect window_done at cycle 16.
  - Then words (ch,data) = (0,0x8F), (1,0x08), (2,0x01), (3,0x00) on 4 consecutive cycles.
  - ch0 saturates at 15 with sat = 1.
- Backpressure: same stimulus with rate_ready low for 5 cycles on ch1 -> rate_data = 0x08, rate_ch = 1 held stable for 5 cycles; ch2 follows 1 cycle after rate_ready rises.
- Dropped window: rate_ready = 0 for 20 cycles while a second window completes with all counts = 3.
  - missed pulses once; window_done does not pulse.
  - Readout resumes with the original first-window values.
- Enable freeze: en low for 10 cycles mid-window with spikes toggling -> counts and wcnt unchanged. The window end is delayed by exactly 10 cycles.
- Boundary spike: spike only on the window-end cycle on ch2 -> snapshot ch2 = 0x01. The first cycle of the next window counts from 0, giving ch2 = 0x00 in the following window.
